// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Brief    : Types and constants shared by the GCD core and its job sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_job_sequencer
// Brief    : Stream front-end for the subtractive GCD core; bypasses zero
//            operands and tags each result with its core-cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CW    = 10,
    parameter int JW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CW-1:0]    out_cycles,
    output logic             out_bypass,
    output logic             core_go,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             busy,
    output logic [JW-1:0]    jobs_done
);

    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             byp_q, byp_d;
    logic [JW-1:0]    jobs_q, jobs_d;

    logic             w_accept;
    logic             w_operand_zero;
    logic [CW-1:0]    w_cnt_inc;

    assign w_accept       = in_valid && (state_q == S_IDLE);
    assign w_operand_zero = (in_a == '0) || (in_b == '0);
    // Saturates so an overlong job reports all-ones rather than wrapping.
    assign w_cnt_inc      = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gcd_d   = gcd_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        byp_d   = byp_q;
        jobs_d  = jobs_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    x_d = in_a;
                    y_d = in_b;
                    if (w_operand_zero) begin
                        // Subtractive GCD would never terminate; gcd(n,0) = n.
                        gcd_d   = in_a | in_b;
                        byp_d   = 1'b1;
                        cyc_d   = '0;
                        state_d = S_RESULT;
                    end else begin
                        byp_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = w_cnt_inc;
                if (core_done) begin
                    gcd_d   = core_result;
                    cyc_d   = w_cnt_inc;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    jobs_d  = jobs_q + JW'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            gcd_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            byp_q   <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gcd_q   <= gcd_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            byp_q   <= byp_d;
            jobs_q  <= jobs_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_RESULT);
    assign core_go    = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign core_x     = x_q;
    assign core_y     = y_q;
    assign out_gcd    = gcd_q;
    assign out_cycles = cyc_q;
    assign out_bypass = byp_q;
    assign jobs_done  = jobs_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_job_sequencer
// Brief    : Directed bench for gcd_job_sequencer with a behavioural GCD core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_job_sequencer;
    import gcd_pkg::*;

    localparam int W = GCD_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [W-1:0] in_a, in_b;

    logic         in_ready, out_valid, out_bypass, core_go, core_done, busy;
    logic [W-1:0] out_gcd, core_x, core_y, core_result;
    logic [9:0]   out_cycles;
    logic [15:0]  jobs_done;

    logic         in_ready8, out_valid8, out_bypass8, core_go8, busy8;
    logic [W-1:0] out_gcd8, core_x8, core_y8;
    logic [7:0]   out_cycles8;
    logic [15:0]  jobs_done8;

    always #5 clk = ~clk;

    gcd_job_sequencer #(.WIDTH(W), .CW(10), .JW(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_cycles(out_cycles), .out_bypass(out_bypass),
        .core_go(core_go), .core_x(core_x), .core_y(core_y),
        .core_done(core_done), .core_result(core_result),
        .busy(busy), .jobs_done(jobs_done)
    );

    // Narrow-counter instance; shares the core model since its timing is identical.
    gcd_job_sequencer #(.WIDTH(W), .CW(8), .JW(16)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid8), .out_ready(out_ready), .out_gcd(out_gcd8),
        .out_cycles(out_cycles8), .out_bypass(out_bypass8),
        .core_go(core_go8), .core_x(core_x8), .core_y(core_y8),
        .core_done(core_done), .core_result(core_result),
        .busy(busy8), .jobs_done(jobs_done8)
    );

    // Behavioural core: IDLE/DONE -go-> LOAD -> CMP -> (SUB -> CMP)* -> DONE
    typedef enum logic [2:0] {C_IDLE, C_LOAD, C_CMP, C_SUB, C_DONE} core_st_t;
    core_st_t     cst;
    logic [W-1:0] cx, cy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cst <= C_IDLE;
            cx  <= '0;
            cy  <= '0;
        end else begin
            case (cst)
                C_IDLE, C_DONE: if (core_go) cst <= C_LOAD;
                C_LOAD: begin
                    cx  <= core_x;
                    cy  <= core_y;
                    cst <= C_CMP;
                end
                C_CMP: cst <= (cx == cy) ? C_DONE : C_SUB;
                C_SUB: begin
                    if (cx > cy) cx <= cx - cy;
                    else         cy <= cy - cx;
                    cst <= C_CMP;
                end
                default: cst <= C_IDLE;
            endcase
        end
    end

    assign core_done   = (cst == C_DONE);
    assign core_result = cx;

    int   go_cnt    = 0;
    int   go8_cnt   = 0;
    int   go_double = 0;
    logic go_prev   = 1'b0;

    always @(posedge clk) begin
        if (core_go)  go_cnt  <= go_cnt + 1;
        if (core_go8) go8_cnt <= go8_cnt + 1;
        if (core_go && go_prev) go_double <= go_double + 1;
        go_prev <= core_go;
    end

    int n_pass  = 0;
    int n_total = 0;
    int exp_jobs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_jobs++;
        check("jobs_done", 32'(jobs_done), 32'(exp_jobs));
        check("jobs_done_cw8", 32'(jobs_done8), 32'(exp_jobs));
        check("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] g, input logic [9:0] cyc,
                           input logic [7:0] cyc8, input logic byp);
        int lat;
        int g0;
        int g80;
        logic ok_xy;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        g0  = go_cnt;
        g80 = go8_cnt;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        lat   = 0;
        ok_xy = 1'b1;
        while (!out_valid && lat < 2000) begin
            if (core_x !== a || core_y !== b || core_x8 !== a || core_y8 !== b) ok_xy = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("result_latency", 32'(lat), byp ? 32'd0 : 32'(cyc) + 32'd1);
        check("core_xy_stable", {31'd0, ok_xy}, 32'd1);
        check("out_gcd", 32'(out_gcd), 32'(g));
        check("out_cycles", 32'(out_cycles), 32'(cyc));
        check("out_bypass", {31'd0, out_bypass}, {31'd0, byp});
        check("out_cycles_cw8", 32'(out_cycles8), 32'(cyc8));
        check("out_gcd_cw8", 32'(out_gcd8), 32'(g));
        check("out_valid_cw8", {30'd0, out_valid8, out_bypass8}, {30'd0, 1'b1, byp});
        check("go_pulses", 32'(go_cnt - g0), byp ? 32'd0 : 32'd1);
        check("go_pulses_cw8", 32'(go8_cnt - g80), byp ? 32'd0 : 32'd1);
        check("busy_in_result", {28'd0, busy, in_ready, busy8, in_ready8}, 32'b1010);
        handshake();
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic [9:0]   cyc;
        logic [7:0]   cyc8;
        logic         byp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic stable;

        vecs[0] = '{a: 8'd12,  b: 8'd8, g: 8'd4, cyc: 10'd7,   cyc8: 8'd7,   byp: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd5, g: 8'd5, cyc: 10'd3,   cyc8: 8'd3,   byp: 1'b0};
        vecs[2] = '{a: 8'd9,   b: 8'd3, g: 8'd3, cyc: 10'd7,   cyc8: 8'd7,   byp: 1'b0};
        vecs[3] = '{a: 8'd0,   b: 8'd7, g: 8'd7, cyc: 10'd0,   cyc8: 8'd0,   byp: 1'b1};
        vecs[4] = '{a: 8'd7,   b: 8'd0, g: 8'd7, cyc: 10'd0,   cyc8: 8'd0,   byp: 1'b1};
        vecs[5] = '{a: 8'd0,   b: 8'd0, g: 8'd0, cyc: 10'd0,   cyc8: 8'd0,   byp: 1'b1};
        vecs[6] = '{a: 8'd255, b: 8'd1, g: 8'd1, cyc: 10'd511, cyc8: 8'd255, byp: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {27'd0, in_ready, out_valid, busy, core_go, out_bypass}, 32'b10000);
        check("reset_data", {8'd0, out_gcd, core_x, core_y}, 32'd0);
        check("reset_counts", {6'd0, out_cycles, jobs_done}, 32'd0);
        check("reset_cw8", {5'd0, in_ready8, out_valid8, busy8, out_cycles8, jobs_done8[7:0],
                            core_go8, out_bypass8, 6'd0}, 32'h0400_0000);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].cyc, vecs[i].cyc8, vecs[i].byp);

        // Backpressure with the next pair already presented.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'd12;
        in_b     = 8'd8;
        @(negedge clk);
        in_a = 8'd6;
        in_b = 8'd4;
        lat  = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd8);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_gcd !== 8'd4 || out_cycles !== 10'd7 ||
                in_ready !== 1'b0 || core_x !== 8'd12 || core_y !== 8'd8) stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        check("bp_jobs_held", 32'(jobs_done), 32'(exp_jobs));
        handshake();
        check("bp_not_accepted_early", {16'd0, core_x, core_y}, {16'd0, 8'd12, 8'd8});
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted_after", {16'd0, core_x, core_y}, {16'd0, 8'd6, 8'd4});
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_gcd", {22'd0, out_cycles}, 32'd7);
        check("bp_second_result", 32'(out_gcd), 32'd2);
        handshake();

        // Reset in the middle of a long job.
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = 8'd255;
        in_b      = 8'd1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_job_busy", {30'd0, busy, out_valid}, 32'b10);
        #2 rst = 1'b1;
        #1;
        check("async_reset_ctrl", {27'd0, busy, in_ready, out_valid, core_go, out_bypass}, 32'b01000);
        check("async_reset_data", {8'd0, out_gcd, core_x, core_y}, 32'd0);
        check("async_reset_counts", {6'd0, out_cycles, jobs_done}, 32'd0);
        check("async_reset_cw8", {7'd0, busy8, out_cycles8, jobs_done8}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        exp_jobs  = 0;
        run_job(8'd6, 8'd4, 8'd2, 10'd7, 8'd7, 1'b0);

        check("go_never_double", 32'(go_double), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
